ts_channel_scheduler: RTL
=========================

Name: ts_channel_scheduler

Overview:
- Packet-level scheduler that sits directly upstream of the 4:1 channel mux.
- Picks which of 4 TS input channels forwards a whole 188-byte packet. Drives the mux select, pops bytes from the chosen channel buffer and writes the mux output into the output FIFO.
- Never splits a packet.
- Checks the sync byte (0x47) of every forwarded packet.

Parameters:
- DATA_WIDTH, 8, byte width of channel/mux data.
- PKT_LEN, 188, bytes per TS packet (bench may override, min 2).
- SPACE_W, 10, width of the FIFO free-space count (must hold PKT_LEN).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ch_pkt_rdy  in  4  bit k=1: channel k buffer holds >=1 complete packet.
- ch_rd_en  out  4  one-hot pop strobe to channel k buffer. Data appears on that buffer's output one cycle later.
- mux_ctrl  out  2  select to the channel mux (00=ch1 .. 11=ch4).
- mux_data  in  DATA_WIDTH  mux output (what the FIFO receives).
- fifo_space  in  SPACE_W  free entries in output FIFO.
- fifo_wr_en  out  1  write strobe to output FIFO.
- pkt_done  out  1  one-cycle pulse with last byte write of a packet.
- sync_err  out  1  one-cycle pulse: first byte of packet was not 0x47.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, mux_ctrl=00, ch_rd_en=0, fifo_wr_en=0, pkt_done=0, sync_err=0, byte_cnt=0, last_grant=3 (so ch index 0 wins first).
  - Reset mid-packet abandons the packet. Partial bytes already in the FIFO are not the block's concern.
- States: IDLE, SEND, TAIL.
- IDLE:
  - Condition: if ch_pkt_rdy!=0 and fifo_space>=PKT_LEN, the round-robin grant is the first ready channel searching last_grant+1, +2, +3, +4 (mod 4).
  - At that edge: mux_ctrl<=grant, last_grant<=grant, byte_cnt<=0, go to SEND. Otherwise stay.
  - ch_rd_en=0 in IDLE.
- SEND:
  - ch_rd_en[grant]=1 every cycle, byte_cnt increments.
  - When byte_cnt==PKT_LEN-1, go to TAIL.
  - Exactly PKT_LEN rd_en cycles per packet, with no stall. Space was reserved at grant, so fifo_space and ch_pkt_rdy are ignored during SEND/TAIL.
- TAIL: no rd_en; go to IDLE.
- Write path:
  - fifo_wr_en is the registered OR of ch_rd_en (1-cycle latency), so the FIFO writes PKT_LEN consecutive cycles, starting the cycle after the first rd_en.
  - mux_ctrl is held constant from the grant edge through the TAIL cycle, so every write sees the granted channel.
- pkt_done is asserted in the same cycle as the final fifo_wr_en (the TAIL cycle).
- sync_err:
  - Registered: pulses 1 cycle after the first fifo_wr_en of a packet if mux_data!=8'h47 on that write.
  - The packet is still forwarded in full.
- Throughput: one packet per PKT_LEN+2 cycles back-to-back (IDLE + PKT_LEN SEND + TAIL).
- fifo_space==PKT_LEN exactly is sufficient; PKT_LEN-1 blocks.
- Channel rdy deasserting after grant: ignored. Rdy sampled only in IDLE.
- All-ready: strict rotation 0,1,2,3,0...
- Single channel ready repeatedly: granted every opportunity.

Decomposition:
- Shared package ts_pkg holds:
  - TS_SYNC_BYTE = 8'h47
  - TS_PKT_LEN = 188
  - the sched_state_t enum {IDLE, SEND, TAIL}
  - a 2-bit ch_sel_t type (shared with the mux select).
- One sub-module: ts_rr_arbiter4 (combinational, inputs: 4-bit request and 2-bit last_grant; outputs: 2-bit grant and valid).
- Counter, FSM and sync check stay in the top.

Test Plan:
- Reset then ch_pkt_rdy=4'b0001, fifo_space=200, PKT_LEN=188:
  - mux_ctrl=00 one cycle after rdy sampled.
  - ch_rd_en=0001 for exactly 188 cycles.
  - fifo_wr_en for 188 cycles lagging by 1.
  - pkt_done coincides with write 188.
- ch_pkt_rdy=4'b1111 held, PKT_LEN=8, space large:
  - mux_ctrl sequence 00,01,10,11,00.
  - Packet starts 10 cycles apart.
- ch_pkt_rdy=4'b0100, fifo_space=187:
  - No rd_en.
  - Raise space to 188 → grant 10 next edge.
- Channel data first byte 0x47:
  - No sync_err.
- Next packet first byte 0x00:
  - sync_err pulses exactly once, 1 cycle after the first write.
  - All 8 bytes still written.
- Assert rst for one cycle at byte 3 of a PKT_LEN=8 packet on channel 2:
  - Next cycle all outputs 0, mux_ctrl=00.
  - With ch_pkt_rdy=0110, next grant is 01 (round-robin restarts at 0).
- Drop ch_pkt_rdy to 0 mid-SEND:
  - Packet completes with full PKT_LEN writes.
  - No new grant afterward.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared types and constants for the TS channel scheduler and its channel mux.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TAIL = 2'd2
    } sched_state_t;

    typedef logic [1:0] ch_sel_t;

    function automatic logic [3:0] ch_onehot(input ch_sel_t sel);
        logic [3:0] v;
        v      = 4'b0000;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ts_channel_scheduler_if.sv
// Scheduler-side bundle: channel buffers and mux on one side, output FIFO on the other.
interface ts_channel_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SPACE_W    = 10
) ();
    import ts_pkg::*;

    logic [3:0]            ch_pkt_rdy;
    logic [3:0]            ch_rd_en;
    ch_sel_t               mux_ctrl;
    logic [DATA_WIDTH-1:0] mux_data;
    logic [SPACE_W-1:0]    fifo_space;
    logic                  fifo_wr_en;
    logic                  pkt_done;
    logic                  sync_err;

    modport master (
        input  ch_pkt_rdy, mux_data, fifo_space,
        output ch_rd_en, mux_ctrl, fifo_wr_en, pkt_done, sync_err
    );

    modport slave (
        output ch_pkt_rdy, mux_data, fifo_space,
        input  ch_rd_en, mux_ctrl, fifo_wr_en, pkt_done, sync_err
    );

endinterface

// File: rtl/ts_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester after i_last_grant wins.
module ts_rr_arbiter4
    import ts_pkg::*;
(
    input  logic [3:0] i_req,
    input  ch_sel_t    i_last_grant,
    output ch_sel_t    o_grant,
    output logic       o_valid
);

    logic [7:0] w_req_dbl;
    logic [2:0] w_shamt;
    logic [3:0] w_rot;
    ch_sel_t    w_offset;

    // Rotate so that bit 0 is the channel right after the previous grant.
    assign w_req_dbl = {i_req, i_req};
    assign w_shamt   = {1'b0, i_last_grant} + 3'd1;
    assign w_rot     = 4'(w_req_dbl >> w_shamt);

    // Priority-encode the rotated request vector.
    always_comb begin
        w_offset = 2'd0;
        o_valid  = 1'b0;
        casez (w_rot)
            4'b???1: begin w_offset = 2'd0; o_valid = 1'b1; end
            4'b??10: begin w_offset = 2'd1; o_valid = 1'b1; end
            4'b?100: begin w_offset = 2'd2; o_valid = 1'b1; end
            4'b1000: begin w_offset = 2'd3; o_valid = 1'b1; end
            default: begin w_offset = 2'd0; o_valid = 1'b0; end
        endcase
    end

    assign o_grant = i_last_grant + 2'd1 + w_offset;

endmodule

// File: rtl/ts_channel_scheduler.sv
// Packet-level round-robin scheduler driving the 4:1 TS channel mux and output FIFO.
// Forwards whole packets only and flags packets whose first byte is not the sync byte.
module ts_channel_scheduler
    import ts_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = TS_PKT_LEN,
    parameter int SPACE_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    ts_channel_scheduler_if.master io_bus
);

    localparam int                    CNT_W     = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(PKT_LEN - 1);
    localparam logic [SPACE_W-1:0]    PKT_SPACE = SPACE_W'(PKT_LEN);
    localparam logic [DATA_WIDTH-1:0] SYNC_WORD = DATA_WIDTH'(TS_SYNC_BYTE);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    ch_sel_t          r_mux_ctrl;
    ch_sel_t          w_mux_nxt;
    ch_sel_t          r_last_grant;
    ch_sel_t          w_last_nxt;
    logic [3:0]       r_ch_rd_en;
    logic [3:0]       w_rd_en_nxt;
    logic             r_fifo_wr_en;
    logic             r_pkt_done;
    logic             w_done_nxt;
    logic             r_first_wr;
    logic             w_first_wr_nxt;
    logic             r_sync_err;
    logic             w_sync_bad;
    ch_sel_t          w_grant;
    logic             w_grant_vld;
    logic             w_space_ok;

    ts_rr_arbiter4 u_arb (
        .i_req        (io_bus.ch_pkt_rdy),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_grant_vld)
    );

    // The full packet's FIFO space is reserved at grant time, so SEND never stalls.
    assign w_space_ok = (io_bus.fifo_space >= PKT_SPACE);
    assign w_sync_bad = r_first_wr & r_fifo_wr_en & (io_bus.mux_data != SYNC_WORD);

    // Next-state and next-output logic for the packet FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_byte_cnt;
        w_mux_nxt      = r_mux_ctrl;
        w_last_nxt     = r_last_grant;
        w_rd_en_nxt    = 4'b0000;
        w_done_nxt     = 1'b0;
        w_first_wr_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld && w_space_ok) begin
                    w_state_nxt = SEND;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_mux_nxt   = w_grant;
                    w_last_nxt  = w_grant;
                    w_rd_en_nxt = ch_onehot(w_grant);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                w_first_wr_nxt = (r_byte_cnt == {CNT_W{1'b0}});
                if (r_byte_cnt == LAST_CNT) begin
                    w_state_nxt = TAIL;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_byte_cnt + CNT_W'(1);
                    w_rd_en_nxt = ch_onehot(r_mux_ctrl);
                end
            end
            TAIL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_byte_cnt   <= {CNT_W{1'b0}};
            r_mux_ctrl   <= 2'd0;
            r_last_grant <= 2'd3;
            r_ch_rd_en   <= 4'b0000;
            r_fifo_wr_en <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_first_wr   <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_cnt_nxt;
            r_mux_ctrl   <= w_mux_nxt;
            r_last_grant <= w_last_nxt;
            r_ch_rd_en   <= w_rd_en_nxt;
            r_fifo_wr_en <= |r_ch_rd_en;
            r_pkt_done   <= w_done_nxt;
            r_first_wr   <= w_first_wr_nxt;
            r_sync_err   <= w_sync_bad;
        end
    end

    assign io_bus.ch_rd_en   = r_ch_rd_en;
    assign io_bus.mux_ctrl   = r_mux_ctrl;
    assign io_bus.fifo_wr_en = r_fifo_wr_en;
    assign io_bus.pkt_done   = r_pkt_done;
    assign io_bus.sync_err   = r_sync_err;

endmodule
